imem_prefetch_buffer: RTL and testbench



---
 rtl/imem_pkg.sv | 19 +
 rtl/fetch_fifo.sv | 71 +++++++
 rtl/imem_prefetch_buffer.sv | 140 ++++++++++++++
 tb/tb_imem_prefetch_buffer.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// Shared types for the instruction prefetch buffer: fetch FSM states and the
// {pc, instr} entry held in the prefetch FIFO.
package imem_pkg;

   localparam int unsigned XLen       = 32;
   localparam int unsigned InstrBytes = 4;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WAIT    = 2'd1,
      DISCARD = 2'd2
   } fetch_state_e;

   typedef struct packed {
      logic [XLen-1:0] pc;
      logic [XLen-1:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO for prefetched entries; head is read straight from
// the storage registers, so a pushed entry is visible the following cycle.
module fetch_fifo #(
   parameter int unsigned Depth = 4,
   parameter type entry_t = logic [63:0],
   localparam int unsigned PtrW = $clog2(Depth),
   localparam int unsigned CntW = $clog2(Depth + 1)
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            flush_i,
   input  logic            push_i,
   input  entry_t          data_i,
   input  logic            pop_i,
   output entry_t          head_o,
   output logic            valid_o,
   output logic [CntW-1:0] count_o
);

   entry_t          mem_q [Depth];
   entry_t          mem_d [Depth];
   logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0] count_q, count_d;
   logic            pop_eff;

   // Popping an empty FIFO is a no-op; flush wins over push and pop.
   assign pop_eff = pop_i && (count_q != '0);

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push_i) begin
            mem_d[wr_ptr_q] = data_i;
            wr_ptr_d        = wr_ptr_q + PtrW'(1);
         end
         if (pop_eff) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
         end
         count_d = count_q + CntW'(push_i) - CntW'(pop_eff);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < int'(Depth); i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   assign head_o  = mem_q[rd_ptr_q];
   assign valid_o = (count_q != '0);
   assign count_o = count_q;

endmodule

// File: rtl/imem_prefetch_buffer.sv
// Sequential instruction prefetcher: one outstanding imem transaction, results
// queued with their PCs for the core; a redirect flushes and refetches.
module imem_prefetch_buffer
   import imem_pkg::*;
#(
   parameter int unsigned       DWidth  = XLen,
   parameter int unsigned       Depth   = 4,
   parameter logic [DWidth-1:0] ResetPc = '0
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              redirect_i,
   input  logic [DWidth-1:0] redirect_pc_i,
   output logic              instr_valid_o,
   output logic [DWidth-1:0] instr_o,
   output logic [DWidth-1:0] instr_pc_o,
   input  logic              instr_ready_i,
   output logic              imem_req_o,
   output logic [DWidth-1:0] imem_addr_o,
   input  logic              imem_ready_i,
   input  logic [DWidth-1:0] imem_rdata_i
);

   localparam int unsigned CntW = $clog2(Depth + 1);

   fetch_state_e      state_q, state_d;
   logic [DWidth-1:0] fetch_pc_q, fetch_pc_d;
   logic              req_q, req_d;
   logic [DWidth-1:0] addr_q, addr_d;

   logic              push_c, pop_c, fifo_valid;
   logic [CntW-1:0]   fifo_count;
   logic [CntW:0]     count_next;
   logic              can_issue;
   logic [DWidth-1:0] redirect_pc_aligned;
   fetch_entry_t      push_entry, head_entry;
   logic              unused_pc_lsb;

   assign redirect_pc_aligned = {redirect_pc_i[DWidth-1:2], 2'b00};
   assign unused_pc_lsb       = ^redirect_pc_i[1:0];

   assign push_c = (state_q == WAIT) && imem_ready_i && !redirect_i;
   assign pop_c  = instr_ready_i && !redirect_i;

   // Occupancy after this cycle; issuing only below Depth reserves the slot.
   assign count_next = (CntW+1)'(fifo_count) + (CntW+1)'(push_c)
                     - (CntW+1)'(pop_c && fifo_valid);
   assign can_issue  = count_next < (CntW+1)'(Depth);

   assign push_entry.pc    = XLen'(addr_q);
   assign push_entry.instr = XLen'(imem_rdata_i);

   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      req_d      = req_q;
      addr_d     = addr_q;
      case (state_q)
         IDLE: begin
            if (redirect_i) begin
               fetch_pc_d = redirect_pc_aligned;
            end else if (can_issue) begin
               state_d    = WAIT;
               req_d      = 1'b1;
               addr_d     = fetch_pc_q;
               fetch_pc_d = fetch_pc_q + DWidth'(InstrBytes);
            end
         end
         WAIT: begin
            if (redirect_i) begin
               fetch_pc_d = redirect_pc_aligned;
               if (imem_ready_i) begin
                  state_d = IDLE;
                  req_d   = 1'b0;
               end else begin
                  state_d = DISCARD;
               end
            end else if (imem_ready_i) begin
               if (can_issue) begin
                  addr_d     = fetch_pc_q;
                  fetch_pc_d = fetch_pc_q + DWidth'(InstrBytes);
               end else begin
                  state_d = IDLE;
                  req_d   = 1'b0;
               end
            end
         end
         DISCARD: begin
            // Stale request stays on the bus until memory completes it.
            if (redirect_i) begin
               fetch_pc_d = redirect_pc_aligned;
            end
            if (imem_ready_i) begin
               state_d = IDLE;
               req_d   = 1'b0;
            end
         end
         default: begin
            state_d = IDLE;
            req_d   = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= IDLE;
         fetch_pc_q <= ResetPc;
         req_q      <= 1'b0;
         addr_q     <= ResetPc;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         req_q      <= req_d;
         addr_q     <= addr_d;
      end
   end

   fetch_fifo #(
      .Depth   (Depth),
      .entry_t (fetch_entry_t)
   ) u_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .flush_i (redirect_i),
      .push_i  (push_c),
      .data_i  (push_entry),
      .pop_i   (pop_c),
      .head_o  (head_entry),
      .valid_o (fifo_valid),
      .count_o (fifo_count)
   );

   assign instr_valid_o = fifo_valid;
   assign instr_o       = DWidth'(head_entry.instr);
   assign instr_pc_o    = DWidth'(head_entry.pc);
   assign imem_req_o    = req_q;
   assign imem_addr_o   = addr_q;

endmodule

// File: tb/tb_imem_prefetch_buffer.sv
// Scoreboard bench for imem_prefetch_buffer: directed scenarios push expected
// PCs, a monitor checks every consumed instruction and the memory handshake.
module tb_imem_prefetch_buffer;

   logic        clk_i = 1'b0;
   logic        rst_ni = 1'b0;
   logic        redirect_i = 1'b0;
   logic [31:0] redirect_pc_i = '0;
   logic        instr_valid_o;
   logic [31:0] instr_o;
   logic [31:0] instr_pc_o;
   logic        instr_ready_i = 1'b0;
   logic        imem_req_o;
   logic [31:0] imem_addr_o;
   logic        imem_ready_i = 1'b0;
   logic [31:0] imem_rdata_i = '0;

   int          checks = 0;
   int          errors = 0;
   int          lat = 1;
   int          mem_cnt = 0;
   bit          mem_prev = 1'b0;
   logic [31:0] exp_q [$];
   logic [31:0] req_log [$];
   logic [31:0] mon_e;
   logic [31:0] mon_prev_addr;
   bit          mon_pend = 1'b0;
   int          k;

   always #5 clk_i = ~clk_i;

   imem_prefetch_buffer dut (
      .clk_i         (clk_i),
      .rst_ni        (rst_ni),
      .redirect_i    (redirect_i),
      .redirect_pc_i (redirect_pc_i),
      .instr_valid_o (instr_valid_o),
      .instr_o       (instr_o),
      .instr_pc_o    (instr_pc_o),
      .instr_ready_i (instr_ready_i),
      .imem_req_o    (imem_req_o),
      .imem_addr_o   (imem_addr_o),
      .imem_ready_i  (imem_ready_i),
      .imem_rdata_i  (imem_rdata_i)
   );

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'h5A5A_A5A5;
   endfunction

   function automatic logic [31:0] log_at(input int i);
      if (i < req_log.size()) return req_log[i];
      return 32'hxxxx_xxxx;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk_i);
         #1;
      end
   endtask

   task automatic drain(input string name, input int budget);
      int n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         cyc(1);
         n++;
      end
      chk({name, "_left"}, 32'(exp_q.size()), 32'd0);
      exp_q.delete();
   endtask

   // Memory model: ready after `lat` idle cycles of a held request.
   initial begin
      forever begin
         @(posedge clk_i);
         #1;
         if (!rst_ni || !imem_req_o) begin
            imem_ready_i = 1'b0;
            mem_cnt      = 0;
         end else begin
            if (mem_prev) mem_cnt = 0;
            if (mem_cnt >= lat) begin
               imem_ready_i = 1'b1;
               imem_rdata_i = mem_word(imem_addr_o);
            end else begin
               imem_ready_i = 1'b0;
            end
            mem_cnt++;
         end
         mem_prev = imem_ready_i;
      end
   end

   // Monitor: handshake stability, request log, instruction scoreboard.
   initial begin
      forever begin
         @(negedge clk_i);
         if (!rst_ni) begin
            mon_pend = 1'b0;
         end else begin
            if (mon_pend) begin
               chk("req_held", 32'(imem_req_o), 32'd1);
               chk("addr_held", imem_addr_o, mon_prev_addr);
            end
            mon_pend      = imem_req_o && !imem_ready_i;
            mon_prev_addr = imem_addr_o;
            if (imem_req_o && imem_ready_i) req_log.push_back(imem_addr_o);
            if (instr_valid_o && instr_ready_i && !redirect_i) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_instr actual_pc=%h expected=none", instr_pc_o);
               end else begin
                  mon_e = exp_q.pop_front();
                  chk("instr_pc", instr_pc_o, mon_e);
                  chk("instr_word", instr_o, mem_word(mon_e));
               end
            end
         end
      end
   end

   initial begin
      // Reset values
      lat = 1;
      instr_ready_i = 1'b1;
      @(negedge clk_i);
      chk("rst_req", 32'(imem_req_o), 32'd0);
      chk("rst_addr", imem_addr_o, 32'h0);
      chk("rst_valid", 32'(instr_valid_o), 32'd0);
      chk("rst_instr", instr_o, 32'h0);
      chk("rst_pc", instr_pc_o, 32'h0);

      // Sequential fetch, 1-cycle memory, first valid 3 cycles after release
      for (int i = 0; i < 6; i++) exp_q.push_back(32'(i * 4));
      req_log.delete();
      @(posedge clk_i);
      #1;
      rst_ni = 1'b1;
      k = 0;
      while (!instr_valid_o && k < 20) begin
         cyc(1);
         k++;
      end
      chk("first_valid_latency", 32'(k), 32'd3);
      drain("seq", 60);
      instr_ready_i = 1'b0;
      chk("seq_log0", log_at(0), 32'h0);
      chk("seq_log1", log_at(1), 32'h4);
      chk("seq_log2", log_at(2), 32'h8);
      cyc(16);
      chk("idle_when_full", 32'(imem_req_o), 32'd0);

      // Zero-wait memory: one instruction per cycle after a redirect
      lat = 0;
      for (int i = 0; i < 8; i++) exp_q.push_back(32'h40 + 32'(i * 4));
      redirect_i    = 1'b1;
      redirect_pc_i = 32'h40;
      instr_ready_i = 1'b1;
      cyc(1);
      redirect_i = 1'b0;
      k = 1;
      while (exp_q.size() != 0 && k < 100) begin
         cyc(1);
         k++;
      end
      chk("throughput_cycles", 32'(k), 32'd11);
      drain("tput", 1);
      instr_ready_i = 1'b0;

      // Stalled core: exactly Depth requests, then one pop frees a slot
      rst_ni = 1'b0;
      cyc(1);
      req_log.delete();
      rst_ni = 1'b1;
      cyc(14);
      chk("full_log_size", 32'(req_log.size()), 32'd4);
      chk("full_log3", log_at(3), 32'hC);
      chk("full_req_off", 32'(imem_req_o), 32'd0);
      chk("full_head_pc", instr_pc_o, 32'h0);
      exp_q.push_back(32'h0);
      instr_ready_i = 1'b1;
      cyc(1);
      instr_ready_i = 1'b0;
      cyc(6);
      chk("refill_log_size", 32'(req_log.size()), 32'd5);
      chk("refill_addr", log_at(4), 32'h10);
      chk("refill_req_off", 32'(imem_req_o), 32'd0);
      for (int i = 1; i < 5; i++) exp_q.push_back(32'(i * 4));
      instr_ready_i = 1'b1;
      drain("refill", 40);
      instr_ready_i = 1'b0;

      // Redirect while 0x8 is outstanding on a slow memory
      lat = 3;
      rst_ni = 1'b0;
      cyc(1);
      req_log.delete();
      exp_q.push_back(32'h0);
      instr_ready_i = 1'b1;
      rst_ni = 1'b1;
      k = 0;
      while (!(imem_req_o && imem_addr_o == 32'h8) && k < 40) begin
         cyc(1);
         k++;
      end
      chk("wait_for_0x8", imem_addr_o, 32'h8);
      redirect_i    = 1'b1;
      redirect_pc_i = 32'h200;
      cyc(1);
      redirect_i = 1'b0;
      chk("discard_valid", 32'(instr_valid_o), 32'd0);
      chk("discard_req", 32'(imem_req_o), 32'd1);
      chk("discard_addr", imem_addr_o, 32'h8);
      exp_q.push_back(32'h200);
      exp_q.push_back(32'h204);
      drain("redir", 60);
      instr_ready_i = 1'b0;
      chk("redir_log2", log_at(2), 32'h8);
      chk("redir_log3", log_at(3), 32'h200);

      // Redirect coinciding with ready: response dropped, straight to IDLE
      req_log.delete();
      k = 0;
      do begin
         @(negedge clk_i);
         k++;
      end while (!(imem_req_o && imem_ready_i) && k < 40);
      chk("same_cycle_ready_seen", 32'(imem_ready_i), 32'd1);
      redirect_i    = 1'b1;
      redirect_pc_i = 32'h103;
      @(posedge clk_i);
      #1;
      redirect_i = 1'b0;
      chk("same_cycle_req_off", 32'(imem_req_o), 32'd0);
      chk("same_cycle_valid", 32'(instr_valid_o), 32'd0);
      exp_q.push_back(32'h100);
      exp_q.push_back(32'h104);
      instr_ready_i = 1'b1;
      drain("same_cycle", 60);
      instr_ready_i = 1'b0;
      chk("same_cycle_next_addr", log_at(1), 32'h100);

      // Fetch address wraps past the top of the address space
      lat = 0;
      redirect_i    = 1'b1;
      redirect_pc_i = 32'hFFFF_FFF8;
      cyc(1);
      redirect_i = 1'b0;
      exp_q.push_back(32'hFFFF_FFF8);
      exp_q.push_back(32'hFFFF_FFFC);
      exp_q.push_back(32'h0000_0000);
      instr_ready_i = 1'b1;
      drain("wrap", 40);
      instr_ready_i = 1'b0;

      // Asynchronous reset in the middle of an outstanding request
      lat = 3;
      k = 0;
      do begin
         @(negedge clk_i);
         k++;
      end while (!(imem_req_o && !imem_ready_i) && k < 40);
      #2;
      rst_ni = 1'b0;
      #1;
      chk("async_rst_req", 32'(imem_req_o), 32'd0);
      chk("async_rst_addr", imem_addr_o, 32'h0);
      chk("async_rst_valid", 32'(instr_valid_o), 32'd0);
      chk("async_rst_instr", instr_o, 32'h0);
      chk("async_rst_pc", instr_pc_o, 32'h0);
      cyc(2);
      req_log.delete();
      exp_q.push_back(32'h0);
      exp_q.push_back(32'h4);
      instr_ready_i = 1'b1;
      rst_ni = 1'b1;
      drain("post_rst", 60);
      instr_ready_i = 1'b0;
      chk("post_rst_first_addr", log_at(0), 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
